// File: rtl/scratch_mem.sv
// Single-port scratch memory with byte enables, fixed-latency read responses,
// out-of-range error reporting and a one-word-per-cycle zero sweep.
module scratch_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    input  logic                clr_start,
    output logic                busy
);

    localparam int NB = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   cnt_reg, cnt_next;
    logic               clr_we;

    logic               in_range;
    logic               req_fire, rd_fire, wr_fire;
    logic [IDX_W-1:0]   addr_idx;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [NB-1:0]      mem_be;
    logic [DATA_W-1:0]  mem_wdata;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  mem_q;
    logic [RD_LAT-1:0]  vld_pipe, err_pipe;
    logic [DATA_W-1:0]  last_data;

    assign req_ready = (state_reg == ST_RUN);
    assign busy      = (state_reg == ST_CLEAR);

    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign addr_idx = req_addr[IDX_W-1:0];
    assign req_fire = req_valid & req_ready;
    assign rd_fire  = req_fire & ~req_we;
    assign wr_fire  = req_fire & req_we & in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_we     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (clr_start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // The sweep owns the write port in CLEAR; requests cannot be accepted there.
    assign mem_we    = clr_we | wr_fire;
    assign mem_idx   = clr_we ? cnt_reg : addr_idx;
    assign mem_be    = clr_we ? {NB{1'b1}} : req_be;
    assign mem_wdata = clr_we ? '0 : req_wdata;

    // Memory is deliberately outside the reset domain so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (rd_fire) mem_q <= mem[addr_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            err_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_fire;
            err_pipe[0] <= rd_fire & ~in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign last_data = mem_q;
        end else begin : g_latn
            logic [DATA_W-1:0] dpipe [RD_LAT-1];
            // Data is zeroed at the first stage so X from an unwritten or
            // out-of-range word never travels down the pipe.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < RD_LAT - 1; i++) dpipe[i] <= '0;
                end else begin
                    dpipe[0] <= (vld_pipe[0] && !err_pipe[0]) ? mem_q : '0;
                    for (int i = 1; i < RD_LAT - 1; i++) dpipe[i] <= dpipe[i-1];
                end
            end
            assign last_data = dpipe[RD_LAT-2];
        end
    endgenerate

    assign rsp_valid = vld_pipe[RD_LAT-1];
    assign rsp_err   = err_pipe[RD_LAT-1];
    assign rsp_data  = (rsp_valid && !rsp_err) ? last_data : '0;

endmodule

// File: tb/tb_scratch_mem.sv
// Directed bench for scratch_mem: four instances cover the default build,
// a short/slow memory with out-of-range addresses, and two 16-word clear builds.
module tb_scratch_mem;

    localparam int N = 4;
    localparam int LAT [N] = '{1, 3, 2, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [N];
    logic        req_we    [N];
    logic [10:0] req_addr  [N];
    logic [15:0] req_wdata [N];
    logic [1:0]  req_be    [N];
    logic        clr_start [N];
    logic        req_ready [N];
    logic        rsp_valid [N];
    logic [15:0] rsp_data  [N];
    logic        rsp_err   [N];
    logic        busy      [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scratch_mem #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .RD_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .clr_start(clr_start[0]), .busy(busy[0]));

    scratch_mem #(.DATA_W(16), .ADDR_W(11), .DEPTH(1000), .RD_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .clr_start(clr_start[1]), .busy(busy[1]));

    scratch_mem #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2][3:0]), .req_wdata(req_wdata[2]),
        .req_be(req_be[2]), .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]),
        .rsp_err(rsp_err[2]), .clr_start(clr_start[2]), .busy(busy[2]));

    scratch_mem #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .RD_LAT(4)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .req_we(req_we[3]), .req_addr(req_addr[3][4:0]), .req_wdata(req_wdata[3]),
        .req_be(req_be[3]), .rsp_valid(rsp_valid[3]), .rsp_data(rsp_data[3]),
        .rsp_err(rsp_err[3]), .clr_start(clr_start[3]), .busy(busy[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int i, input int a, input logic [15:0] d, input logic [1:0] be);
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b1;
        req_addr[i]  = 11'(a);
        req_wdata[i] = d;
        req_be[i]    = be;
        step();
        req_valid[i] = 1'b0;
        req_we[i]    = 1'b0;
        $display("dut%0d write addr=%0d data=%h be=%b", i, a, d, be);
    endtask

    // Issues one read, checks silence until the scheduled cycle, the response, then the pulse end.
    task automatic rd(input int i, input int a, input logic [15:0] d, input logic e);
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b0;
        req_addr[i]  = 11'(a);
        step();
        req_valid[i] = 1'b0;
        for (int k = 1; k < LAT[i]; k++) begin
            chk("rd_early_valid", 32'(rsp_valid[i]), 32'd0);
            step();
        end
        chk("rd_valid", 32'(rsp_valid[i]), 32'd1);
        chk("rd_data", 32'(rsp_data[i]), 32'(d));
        chk("rd_err", 32'(rsp_err[i]), 32'(e));
        $display("dut%0d read addr=%0d data=%h err=%0d (exp %h/%0d)", i, a, rsp_data[i], rsp_err[i], d, e);
        step();
        chk("rd_pulse_end", 32'(rsp_valid[i]), 32'd0);
        chk("rd_idle_data", 32'(rsp_data[i]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_be[i] = '0;   clr_start[i] = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < N; i++) begin
            chk("reset_ready", 32'(req_ready[i]), 32'd1);
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_valid", 32'(rsp_valid[i]), 32'd0);
            chk("reset_data", 32'(rsp_data[i]), 32'd0);
        end
        reset = 1'b0;
        step();

        // Default build: full write, byte merge, be=0 no-op, read right after write.
        wr(0, 5, 16'hBEEF, 2'b11);
        rd(0, 5, 16'hBEEF, 1'b0);
        wr(0, 7, 16'h1234, 2'b11);
        wr(0, 7, 16'hABCD, 2'b01);
        rd(0, 7, 16'h12CD, 1'b0);
        wr(0, 7, 16'hFFFF, 2'b00);
        rd(0, 7, 16'h12CD, 1'b0);
        wr(0, 7, 16'h5600, 2'b10);
        rd(0, 7, 16'h56CD, 1'b0);
        wr(0, 2047, 16'h7E57, 2'b11);
        rd(0, 2047, 16'h7E57, 1'b0);

        // DEPTH=1000, RD_LAT=3: discarded out-of-range write, error reads, top word.
        wr(1, 476, 16'h5555, 2'b11);
        wr(1, 1500, 16'hAAAA, 2'b11);
        rd(1, 1500, 16'h0000, 1'b1);
        rd(1, 476, 16'h5555, 1'b0);
        wr(1, 999, 16'h0999, 2'b11);
        rd(1, 999, 16'h0999, 1'b0);
        rd(1, 1000, 16'h0000, 1'b1);

        // RD_LAT=2 back-to-back reads of 0..9: responses in slots 2..11.
        for (int a = 0; a < 10; a++) wr(2, a, 16'hA000 + 16'(a), 2'b11);
        for (int s = 0; s < 14; s++) begin
            if (s >= 2 && s <= 11) begin
                chk("b2b_valid", 32'(rsp_valid[2]), 32'd1);
                chk("b2b_data", 32'(rsp_data[2]), 32'h0000A000 + 32'(s - 2));
                $display("dut2 b2b slot=%0d data=%h", s, rsp_data[2]);
            end else begin
                chk("b2b_idle", 32'(rsp_valid[2]), 32'd0);
            end
            chk("b2b_err", 32'(rsp_err[2]), 32'd0);
            req_valid[2] = (s < 10);
            req_we[2]    = 1'b0;
            req_addr[2]  = 11'(s);
            step();
        end

        // Clear sweep with a read accepted on the clr_start edge.
        for (int a = 0; a < 16; a++) wr(2, a, 16'hFFFF, 2'b11);
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 11'd3; clr_start[2] = 1'b1;
        step();
        req_valid[2] = 1'b0; clr_start[2] = 1'b0;
        for (int s = 0; s < 20; s++) begin
            chk("clr_busy", 32'(busy[2]), 32'(s < 16));
            chk("clr_ready", 32'(req_ready[2]), 32'(s >= 16));
            if (s == 1) begin
                chk("clr_inflight_valid", 32'(rsp_valid[2]), 32'd1);
                chk("clr_inflight_data", 32'(rsp_data[2]), 32'h0000FFFF);
            end else begin
                chk("clr_no_rsp", 32'(rsp_valid[2]), 32'd0);
            end
            $display("dut2 clear slot=%0d busy=%0d ready=%0d", s, busy[2], req_ready[2]);
            clr_start[2] = (s == 5);
            step();
        end
        for (int a = 0; a < 16; a++) rd(2, a, 16'h0000, 1'b0);

        // Reset two cycles into a clear with a RD_LAT=4 read still in flight.
        for (int a = 0; a < 16; a++) wr(3, a, 16'hFFFF, 2'b11);
        req_valid[3] = 1'b1; req_we[3] = 1'b0; req_addr[3] = 11'd9; clr_start[3] = 1'b1;
        step();
        req_valid[3] = 1'b0; clr_start[3] = 1'b0;
        step();
        step();
        chk("pre_reset_busy", 32'(busy[3]), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy[3]), 32'd0);
        chk("rst_ready", 32'(req_ready[3]), 32'd1);
        chk("rst_valid", 32'(rsp_valid[3]), 32'd0);
        chk("rst_data", 32'(rsp_data[3]), 32'd0);
        $display("dut3 reset mid-clear busy=%0d valid=%0d", busy[3], rsp_valid[3]);
        step();
        step();
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            chk("rst_flushed", 32'(rsp_valid[3]), 32'd0);
            step();
        end
        for (int a = 0; a < 16; a++) rd(3, a, (a < 2) ? 16'h0000 : 16'hFFFF, 1'b0);
        rd(3, 20, 16'h0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
